// File: rtl/logic_unit_seq.sv
// Sliced bitwise logic unit: applies one of eight bitwise functions SLICE bits per cycle,
// with valid/ready handshakes on both sides and a zero flag on the completed result.
module logic_unit_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             zero_q, zero_d;
   logic             valid_q, valid_d;

   logic [WIDTH-1:0] res_full;
   logic [SLICE-1:0] res_sl;
   int unsigned      base;

   // Full-width function of the captured operands; RUN picks one slice per cycle.
   always_comb begin
      res_full = '0;
      unique case (op_q)
         3'b000: res_full = a_q & b_q;
         3'b001: res_full = a_q | b_q;
         3'b010: res_full = a_q ^ b_q;
         3'b011: res_full = ~(a_q | b_q);
         3'b100: res_full = ~(a_q & b_q);
         3'b101: res_full = ~(a_q ^ b_q);
         3'b110: res_full = a_q & ~b_q;
         3'b111: res_full = a_q;
      endcase
   end

   assign base   = 32'(cnt_q) * SLICE;
   assign res_sl = res_full[base +: SLICE];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      out_d   = out_q;
      zero_d  = zero_q;
      valid_d = valid_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = in1;
               b_d     = in2;
               op_d    = op;
               out_d   = '0;
               zero_d  = 1'b1;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            out_d[base +: SLICE] = res_sl;
            zero_d = zero_q & (res_sl == '0);
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               valid_d = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         out_q   <= '0;
         zero_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         out_q   <= out_d;
         zero_q  <= zero_d;
         valid_q <= valid_d;
      end
   end

   // Held low during reset so nothing is accepted while the unit is being cleared.
   assign in_ready  = rst_n && (state_q == StIdle);
   assign out_valid = valid_q;
   assign out       = out_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Scoreboard bench for logic_unit_seq: three configurations (32/8, 16/16, 64/16) checked
// against a per-bit truth-table model of the eight functions.
module tb_logic_unit_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [2:0]  op_r;
   logic [63:0] a_r, b_r;
   logic [2:0]  iv, ir, ov, ordy, zz;
   logic [31:0] o32;
   logic [15:0] o16;
   logic [63:0] o64;

   int          n_cmp = 0;
   int          n_bad = 0;
   int unsigned cyc = 0;
   bit          rnd_bp = 0;

   typedef struct {
      logic [63:0] o;
      logic        z;
      int unsigned t;
   } exp_t;

   exp_t        sb[3][$];
   bit          seen[3];
   int          nsl[3] = '{4, 1, 4};
   int          wid[3] = '{32, 16, 64};
   logic [3:0]  tt_tab[8];

   logic_unit_seq #(.WIDTH(32), .SLICE(8)) u32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .op(op_r),
      .in1(a_r[31:0]), .in2(b_r[31:0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .out(o32), .zero(zz[0]));

   logic_unit_seq #(.WIDTH(16), .SLICE(16)) u16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .op(op_r),
      .in1(a_r[15:0]), .in2(b_r[15:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .out(o16), .zero(zz[1]));

   logic_unit_seq #(.WIDTH(64), .SLICE(16)) u64 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .op(op_r),
      .in1(a_r), .in2(b_r), .out_valid(ov[2]), .out_ready(ordy[2]),
      .out(o64), .zero(zz[2]));

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (rnd_bp) #1 ordy[2] = 1'($urandom_range(0, 1));

   function automatic logic [63:0] dout(int k);
      if (k == 0) return {32'b0, o32};
      if (k == 1) return {48'b0, o16};
      return o64;
   endfunction

   // Each op is a 4-entry truth table indexed by {a_bit, b_bit}.
   function automatic logic [63:0] model(logic [2:0] f, logic [63:0] a, logic [63:0] b, int w);
      logic [63:0] r;
      logic [3:0]  tt;
      r  = '0;
      tt = tt_tab[f];
      for (int i = 0; i < w; i++) r[i] = tt[{a[i], b[i]}];
      return r;
   endfunction

   task automatic check(string name, logic [63:0] got, logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   task automatic issue(int k, logic [2:0] f, logic [63:0] a, logic [63:0] b);
      exp_t        e;
      logic [63:0] m;
      bit          ok;
      ok = 0;
      m  = (wid[k] == 64) ? '1 : ((64'd1 << wid[k]) - 64'd1);
      @(negedge clk);
      op_r  = f;
      a_r   = a;
      b_r   = b;
      iv[k] = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (ir[k]) begin
            @(posedge clk);
            ok  = 1;
            e.t = cyc;
            e.o = model(f, a & m, b & m, wid[k]);
            e.z = (e.o == '0);
            sb[k].push_back(e);
         end else begin
            @(negedge clk);
         end
      end
      #1 iv[k] = 1'b0;
      if (!ok) check($sformatf("accept_timeout%0d", k), 64'd0, 64'd1);
   endtask

   task automatic wait_done(int k);
      for (int i = 0; i < 300 && sb[k].size() != 0; i++) @(negedge clk);
      if (sb[k].size() != 0) begin
         check($sformatf("done_timeout%0d", k), 64'(sb[k].size()), 64'd0);
         sb[k].delete();
      end
   endtask

   // Monitor: latency on the rising out_valid, value/zero on the handshake cycle.
   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         if (!rst_n || !ov[k]) begin
            seen[k] = 0;
         end else begin
            if (!seen[k]) begin
               seen[k] = 1;
               if (sb[k].size() == 0)
                  check($sformatf("unexpected_valid%0d", k), 64'd1, 64'd0);
               else
                  check($sformatf("latency%0d", k), 64'(cyc - sb[k][0].t), 64'(nsl[k] + 1));
            end
            if (ordy[k] && sb[k].size() != 0) begin
               e = sb[k].pop_front();
               check($sformatf("out%0d", k), dout(k), e.o);
               check($sformatf("zero%0d", k), 64'(zz[k]), 64'(e.z));
               seen[k] = 0;
            end
         end
      end
   end

   initial begin
      repeat (30000) @(posedge clk);
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tt_tab = '{4'b1000, 4'b1110, 4'b0110, 4'b0001, 4'b0111, 4'b1001, 4'b0100, 4'b1100};
      rst_n = 1'b0;
      iv    = '0;
      ordy  = 3'b111;
      op_r  = '0;
      a_r   = '0;
      b_r   = '0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_in_ready%0d", k), 64'(ir[k]), 64'd0);
         check($sformatf("rst_out_valid%0d", k), 64'(ov[k]), 64'd0);
         check($sformatf("rst_out%0d", k), dout(k), 64'd0);
         check($sformatf("rst_zero%0d", k), 64'(zz[k]), 64'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_reset", 64'(ir), 64'h7);

      // NOR and the zero flag
      issue(0, 3'b011, 64'hF0F0_0000, 64'h0F0F_0000);
      wait_done(0);
      issue(0, 3'b000, 64'hAAAA_AAAA, 64'h5555_5555);
      wait_done(0);
      issue(0, 3'b010, 64'hAAAA_AAAA, 64'h5555_5555);
      wait_done(0);

      // Back-pressure: result held, no acceptance in DONE
      ordy[0] = 1'b0;
      issue(0, 3'b110, 64'h1234_5678, 64'h0000_FFFF);
      for (int i = 0; i < 50 && !ov[0]; i++) @(negedge clk);
      check("bp_valid", 64'(ov[0]), 64'd1);
      iv[0] = 1'b1;
      op_r  = 3'b001;
      a_r   = 64'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out", 64'(o32), 64'h1234_0000);
         check("bp_zero", 64'(zz[0]), 64'd0);
         check("bp_in_ready", 64'(ir[0]), 64'd0);
         check("bp_hold_valid", 64'(ov[0]), 64'd1);
      end
      @(posedge clk);
      #1 ordy[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_idle_ready", 64'(ir[0]), 64'd1);
      check("bp_idle_valid", 64'(ov[0]), 64'd0);
      iv[0] = 1'b0;
      wait_done(0);

      // Reset in the middle of RUN
      issue(0, 3'b001, 64'h1122_3344, 64'h0102_0304);
      repeat (3) @(negedge clk);
      check("partial_low_slices", 64'(o32[15:0]), 64'h3344);
      check("partial_valid", 64'(ov[0]), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      check("abort_out", 64'(o32), 64'd0);
      check("abort_valid", 64'(ov[0]), 64'd0);
      check("abort_in_ready", 64'(ir[0]), 64'd0);
      sb[0].delete();
      @(negedge clk);
      rst_n = 1'b1;
      issue(0, 3'b101, {$urandom, $urandom}, {$urandom, $urandom});
      wait_done(0);

      // Operand hold: inputs churn during RUN
      for (int n = 0; n < 6; n++) begin
         issue(0, 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom});
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            op_r = 3'($urandom_range(0, 7));
            a_r  = {$urandom, $urandom};
            b_r  = {$urandom, $urandom};
         end
         wait_done(0);
      end

      // Single-slice configuration
      issue(1, 3'b100, 64'hFFFF, 64'h00FF);
      wait_done(1);
      for (int f = 0; f < 8; f++) begin
         issue(1, 3'(f), {$urandom, $urandom}, {$urandom, $urandom});
         wait_done(1);
      end

      // Wide configuration, all ops, random output back-pressure
      rnd_bp = 1;
      for (int f = 0; f < 8; f++)
         for (int r = 0; r < 3; r++)
            issue(2, 3'(f), {$urandom, $urandom}, {$urandom, $urandom});
      @(negedge clk);
      rnd_bp = 0;
      @(posedge clk);
      #1 ordy[2] = 1'b1;
      wait_done(2);
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/logic_unit_seq.md
Name: logic_unit_seq

Overview:
- Parametrised successor to the fixed 32-bit bitwise NOR cell in the ALU datapath.
- Computes one of eight bitwise functions over WIDTH-bit operands, processing SLICE bits per cycle.
- Uses a valid/ready handshake on both input and output, so it can sit between the operand registers and the ALU result mux.
- Also produces a zero flag for the branch logic.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SLICE, 8, bits processed per cycle. Must divide WIDTH exactly; SLICE == WIDTH is legal.
- NSLICE, WIDTH/SLICE, derived and not overridable. Number of RUN cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  unit can accept a new operation.
- op  input  3  function select: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 NAND, 101 XNOR, 110 ANDN (in1 & ~in2), 111 PASS (in1).
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- out_valid  output  1  out and zero hold a completed result.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  result.
- zero  output  1  set when the result is all zeros.

Behaviour:
- Reset: asynchronous on rst_n low.
  - State goes to IDLE; slice counter 0; captured operands and op 0.
  - out = 0, zero = 0, out_valid = 0.
  - in_ready = 0 while rst_n is low, and 1 from the first cycle after deassertion.
  - Reset during RUN or DONE aborts the operation; no partial result is ever flagged valid.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready = 1. On in_valid && in_ready at a clock edge:
    - capture in1, in2 and op;
    - clear out to 0, set the zero accumulator to 1, counter = 0;
    - go to RUN.
  - RUN: in_ready = 0, out_valid = 0. Each cycle:
    - compute slice k = counter, i.e. bits [k*SLICE +: SLICE], from the captured operands;
    - write it into out[k*SLICE +: SLICE];
    - AND the zero accumulator with (slice == 0);
    - increment the counter.
    - On the cycle processing slice NSLICE-1, go to DONE.
  - DONE: out_valid = 1, in_ready = 0. out and zero are held stable. On out_ready high at a clock edge, go to IDLE and drop out_valid.
  - out_valid and zero are registered outputs. in_ready is combinational from state (and reset).
- Latency: accept at edge T0 gives out_valid high after edge T0 + NSLICE (NSLICE = 4 for the defaults). Minimum initiation interval is NSLICE + 2 cycles.
  - There is no acceptance in DONE even if out_ready is high in the same cycle; acceptance happens only from IDLE.
- Input behaviour:
  - Inputs are sampled only at the accept edge. Changes to in1, in2 or op during RUN or DONE have no effect.
  - in_valid while in_ready = 0 is ignored. The producer must hold its request until it sees in_ready.
- Output behaviour:
  - out_ready while out_valid = 0 is ignored.
  - out keeps the last completed result in IDLE until the next accept clears it.
- Arithmetic: purely bitwise, with no carry or width growth. Every op is defined for all bit patterns; there is no illegal op.
- Counter: width clog2(NSLICE), with a minimum of 1 bit. It wraps to 0 when entering DONE.

Test Plan:
1. NOR, WIDTH=32, SLICE=8: in1 = 0xF0F0_0000, in2 = 0x0F0F_0000, op = 011 → out = 0x0000_FFFF, zero = 0. out_valid rises exactly 4 cycles after the accept edge.
2. AND zero flag: in1 = 0xAAAA_AAAA, in2 = 0x5555_5555, op = 000 → out = 0x0000_0000, zero = 1. Then XOR on the same operands → out = 0xFFFF_FFFF, zero = 0.
3. Back-pressure: complete an ANDN with in1 = 0x1234_5678, in2 = 0x0000_FFFF → out = 0x1234_0000.
   - Hold out_ready low 5 cycles: out and zero stay stable, in_ready = 0, and a new in_valid is not accepted.
   - Raise out_ready: the unit returns to IDLE one cycle later.
4. Reset mid-RUN: accept an OR, then pull rst_n low after 2 RUN cycles.
   - out = 0, out_valid = 0 and in_ready = 0 immediately, with no clock needed.
   - After release, a new op completes correctly with full latency.
5. Operand hold: change in1/in2/op every cycle during RUN → the result matches the values captured at the accept edge.
6. Configuration SLICE = WIDTH = 16, NAND: in1 = 0xFFFF, in2 = 0x00FF → out = 0xFF00, out_valid one cycle after accept. Also run all 8 ops with WIDTH = 64, SLICE = 16 against a reference model using random operands.
